// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit in front of the data RAM.
// Contents: FSM state encoding, RV32I funct3 size codes, and the
// access legality check used when a request is accepted.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ADDR,
    S_LD_DATA,
    S_RMW_ADDR,
    S_RMW_MERGE,
    S_ST_WR
  } state_t;

  // RV32I funct3 for loads/stores (bit 2 = unsigned, bits [1:0] = size).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Full-word access: needs no read-modify-write and no lane extraction.
  function automatic logic is_word(input logic [2:0] funct3);
    return funct3[1:0] == 2'b10;
  endfunction

  // Illegal encoding (reserved funct3, or unsigned store) or misaligned address.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                 (funct3 == 3'b111) || (we && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath of the load/store unit (purely combinational).
// Ports:
//   funct3     in  3   access size/signedness of the latched request
//   offset     in  2   byte offset inside the word (addr[1:0])
//   word       in  32  word read from the RAM
//   wdata      in  32  right-aligned store data (only the low byte/half is used)
//   load_data  out 32  selected lane, sign- or zero-extended
//   store_word out 32  word with the store lane replaced by wdata
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        unused_wdata;

  // Store data above the half-word is never merged into memory.
  assign unused_wdata = ^wdata[31:16];

  // Little-endian: byte n sits at bits [8n+7:8n].
  assign lane_b = word[{offset, 3'b000} +: 8];
  assign lane_h = word[{offset[1], 4'b0000} +: 16];

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    load_data = '0;
    unique case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h0, lane_b};
      F3_HU:   load_data = {16'h0, lane_h};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3[1:0])
      2'b00:   store_word[{offset, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit directly upstream of a word-addressed, single-write-enable
// data RAM. Turns RV32I byte/half/word loads and stores into word accesses,
// extends load data and performs read-modify-write for sub-word stores.
// Misaligned or illegal requests are answered with an error and never reach
// the RAM.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   req_*        core request: valid/ready handshake, we, funct3, byte addr, wdata
//   rsp_*        one-cycle completion pulse with error flag and load data
//   daddr        RAM word address (held between accesses)
//   mem0_ena_w   RAM write enable, one cycle per store
//   ddata_w      RAM write data
//   ddata_r      RAM read data, valid the cycle after daddr is presented
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic                  mem0_ena_w,
  output logic [DATA_WIDTH-1:0] ddata_w,
  input  logic [DATA_WIDTH-1:0] ddata_r
);

  state_t          state;
  logic [2:0]      funct3_q;
  logic [1:0]      offset_q;
  logic [31:0]     wdata_q;
  logic [31:0]     load_data;
  logic [31:0]     store_word;
  logic            unused_addr;

  // Byte-address bits above the RAM range are ignored: word addresses wrap.
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  // Ready is a pure decode of the state register.
  assign req_ready = (state == S_IDLE);

  lsu_align u_align (
    .funct3     (funct3_q),
    .offset     (offset_q),
    .word       (ddata_r),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      funct3_q   <= '0;
      offset_q   <= '0;
      wdata_q    <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      daddr      <= '0;
      mem0_ena_w <= 1'b0;
      ddata_w    <= '0;
    end else begin
      // Pulses default low; the branches below raise them for one cycle.
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      mem0_ena_w <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            offset_q <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (access_err(req_we, req_funct3, req_addr[1:0])) begin
              // Rejected in place: answer immediately, RAM untouched, daddr kept.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              daddr <= req_addr[ADDR_WIDTH+1:2];
              if (!req_we) begin
                state <= S_LD_ADDR;
              end else if (is_word(req_funct3)) begin
                // Full word: write straight away, no read needed.
                state      <= S_ST_WR;
                mem0_ena_w <= 1'b1;
                ddata_w    <= req_wdata;
              end else begin
                state <= S_RMW_ADDR;
              end
            end
          end
        end

        // RAM is reading daddr; data arrives next cycle.
        S_LD_ADDR: state <= S_LD_DATA;

        S_LD_DATA: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
          state     <= S_IDLE;
        end

        S_RMW_ADDR: state <= S_RMW_MERGE;

        // Old word is on ddata_r: splice in the new lane and arm the write.
        S_RMW_MERGE: begin
          ddata_w    <= store_word;
          mem0_ena_w <= 1'b1;
          state      <= S_ST_WR;
        end

        S_ST_WR: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl with a behavioural synchronous RAM.
// Expected responses are queued at acceptance and compared when rsp_valid
// appears, including the number of clock edges from acceptance to response.
module tb_lsu_dmem_ctrl;
  import lsu_pkg::*;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [AW-1:0] daddr;
  logic        mem0_ena_w;
  logic [31:0] ddata_w;
  logic [31:0] ddata_r;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .daddr      (daddr),
    .mem0_ena_w (mem0_ena_w),
    .ddata_w    (ddata_w),
    .ddata_r    (ddata_r)
  );

  // Synchronous RAM model plus a log of every write cycle.
  logic [31:0]   mem [0:(1<<AW)-1];
  int            wr_count = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [31:0]   last_wr_data = '0;

  always @(posedge clk) begin
    if (mem0_ena_w) begin
      mem[daddr]   <= ddata_w;
      wr_count     <= wr_count + 1;
      last_wr_addr <= daddr;
      last_wr_data <= ddata_w;
    end
    ddata_r <= mem[daddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // edges = clock edges from the accept edge to the edge that raises rsp_valid.
  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          edges;
    time         t_acc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_err"},   32'(rsp_err), 32'(e.err));
        check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
        check({e.tag, "_edges"}, 32'(($time - e.t_acc - 5) / 10), 32'(e.edges));
      end
    end
  end

  // Drives a request at a falling edge and keeps req_valid up until an edge
  // with req_ready high accepts it. Returns just after the accept edge with
  // req_valid still asserted; waits counts falling edges spent with ready low.
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input int edges, input bit expect_rsp,
                       output int waits, output logic rsp_at_accept);
    logic rdy;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    waits         = 0;
    rdy           = req_ready;
    rsp_at_accept = rsp_valid;
    while (!rdy && waits < 50) begin
      @(negedge clk);
      waits++;
      rdy           = req_ready;
      rsp_at_accept = rsp_valid;
    end
    if (!rdy) begin
      check({tag, "_accept_timeout"}, 32'(rdy), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.tag   = tag;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    e.edges = edges;
    e.t_acc = $time;
    if (expect_rsp) sb.push_back(e);
  endtask

  task automatic req(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_rdata, input int edges);
    int   w;
    logic r;
    issue(tag, we, f3, addr, wdata, exp_err, exp_rdata, edges, 1'b1, w, r);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  int   wr0;
  int   waits;
  logic rsp_at;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready",  32'(req_ready), 32'd1);
    check("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    check("rst_rsp_err",    32'(rsp_err), 32'd0);
    check("rst_rsp_rdata",  rsp_rdata, 32'd0);
    check("rst_daddr",      32'(daddr), 32'd0);
    check("rst_mem0_ena_w", 32'(mem0_ena_w), 32'd0);
    check("rst_ddata_w",    ddata_w, 32'd0);
    rst_n = 1'b1;

    // 1: word store, no read-modify-write.
    wr0 = wr_count;
    req("sw_8", 1'b1, F3_W, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0, 1);
    drain();
    check("sw_8_writes", 32'(wr_count - wr0), 32'd1);
    check("sw_8_waddr",  32'(last_wr_addr), 32'd2);
    check("sw_8_wdata",  last_wr_data, 32'hDEADBEEF);

    // 2: loads of every size and signedness from word 2.
    req("lb_9",  1'b0, F3_B,  32'h9, 32'h0, 1'b0, 32'hFFFFFFBE, 2);
    req("lbu_9", 1'b0, F3_BU, 32'h9, 32'h0, 1'b0, 32'h000000BE, 2);
    req("lh_a",  1'b0, F3_H,  32'hA, 32'h0, 1'b0, 32'hFFFFDEAD, 2);
    req("lhu_a", 1'b0, F3_HU, 32'hA, 32'h0, 1'b0, 32'h0000DEAD, 2);
    req("lw_8",  1'b0, F3_W,  32'h8, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    drain();

    // 3: byte store into the top lane, then read back.
    wr0 = wr_count;
    req("sb_b", 1'b1, F3_B, 32'hB, 32'h00000012, 1'b0, 32'h0, 3);
    drain();
    check("sb_b_writes", 32'(wr_count - wr0), 32'd1);
    check("sb_b_waddr",  32'(last_wr_addr), 32'd2);
    check("sb_b_wdata",  last_wr_data, 32'h12ADBEEF);
    req("lw_8_after_sb", 1'b0, F3_W, 32'h8, 32'h0, 1'b0, 32'h12ADBEEF, 2);
    drain();

    // 4: rejected requests answer at the accept edge and never write.
    wr0 = wr_count;
    req("err_lw_6",   1'b0, F3_W,   32'h6, 32'h0, 1'b1, 32'h0, 0);
    req("err_sh_3",   1'b1, F3_H,   32'h3, 32'hFFFF, 1'b1, 32'h0, 0);
    req("err_f3_011", 1'b0, 3'b011, 32'h8, 32'h0, 1'b1, 32'h0, 0);
    req("err_sbu",    1'b1, F3_BU,  32'h8, 32'h55, 1'b1, 32'h0, 0);
    drain();
    check("err_writes", 32'(wr_count - wr0), 32'd0);

    // 5: reset in the middle of a read-modify-write.
    wr0 = wr_count;
    issue("sb_rst", 1'b1, F3_B, 32'hB, 32'h00000055, 1'b0, 32'h0, 3, 1'b0, waits, rsp_at);
    @(negedge clk);              // RMW_ADDR
    req_valid = 1'b0;
    @(negedge clk);              // RMW_MERGE
    rst_n = 1'b0;
    #1;
    check("rst_mid_ena_w",  32'(mem0_ena_w), 32'd0);
    check("rst_mid_ready",  32'(req_ready), 32'd1);
    check("rst_mid_ddata_w", ddata_w, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready",  32'(req_ready), 32'd1);
    check("rst_rel_writes", 32'(wr_count - wr0), 32'd0);
    check("rst_rel_word2",  mem[2], 32'h12ADBEEF);
    req("lw_8_after_rst", 1'b0, F3_W, 32'h8, 32'h0, 1'b0, 32'h12ADBEEF, 2);
    drain();

    // 6: back-to-back with req_valid held; second store wraps onto word 2.
    wr0 = wr_count;
    req("b2b_lw_8", 1'b0, F3_W, 32'h8, 32'h0, 1'b0, 32'h12ADBEEF, 2);
    issue("b2b_sw_1008", 1'b1, F3_W, 32'h1008, 32'hCAFEF00D, 1'b0, 32'h0, 1, 1'b1,
          waits, rsp_at);
    check("b2b_busy_cycles", 32'(waits), 32'd2);
    check("b2b_accept_in_rsp", 32'(rsp_at), 32'd1);
    drain();
    check("b2b_writes", 32'(wr_count - wr0), 32'd1);
    check("b2b_waddr",  32'(last_wr_addr), 32'd2);
    check("b2b_word2",  mem[2], 32'hCAFEF00D);

    // Half-word merge into the upper lane, then sub-word readback.
    req("sh_a",    1'b1, F3_H,  32'hA, 32'h5555ABCD, 1'b0, 32'h0, 3);
    req("lh_a2",   1'b0, F3_H,  32'hA, 32'h0, 1'b0, 32'hFFFFABCD, 2);
    req("lhu_8",   1'b0, F3_HU, 32'h8, 32'h0, 1'b0, 32'h0000F00D, 2);
    req("lbu_8",   1'b0, F3_BU, 32'h8, 32'h0, 1'b0, 32'h0000000D, 2);
    req("lb_b",    1'b0, F3_B,  32'hB, 32'h0, 1'b0, 32'hFFFFFFAB, 2);
    drain();
    check("sh_a_word2", mem[2], 32'hABCDF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
